// File: rtl/caches_types_pkg.sv
// Enumerations shared between the caches, the arbiter and the RAM model.
package caches_types_pkg;
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arb_state_t;
endpackage

// File: rtl/cpu_types_pkg.sv
// Core-wide scalar types shared by the pipeline and the memory side.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating icache starvation counter; reached is high once cnt hits limit.
module arb_starve_ctr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic         reached
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt < limit)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign reached = (cnt >= limit);
endmodule

// File: rtl/mem_arbiter.sv
// Icache/dcache arbiter in front of the single-ported RAM.
// Define ARB_STATS_EN to build the per-requester beat counters.
module mem_arbiter
  import cpu_types_pkg::*;
  import caches_types_pkg::*;
#(
  parameter int BLOCK_WORDS  = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  word_t       iaddr,
  output word_t       iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  word_t       daddr,
  input  word_t       dstore,
  output word_t       dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output word_t       ramaddr,
  output word_t       ramstore,
  input  word_t       ramload,
  input  logic [1:0]  ramstate,
  output logic        ram_err,
  output word_t       igrant_count,
  output word_t       dgrant_count
);
  localparam int BW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [BW-1:0] LAST  = BW'(BLOCK_WORDS - 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  arb_state_t    state, state_n;
  logic [BW-1:0] beat_cnt, beat_cnt_n;
  ramstate_t     rs;
  logic          access;
  logic          dreq;
  logic          ibeat;
  logic          starved;
  logic          err_q;

  assign rs     = ramstate_t'(ramstate);
  assign access = (rs == ACCESS);
  assign dreq   = dREN | dWEN;
  assign ibeat  = (state == IGNT) && access;

  arb_starve_ctr #(.W(SW)) u_starve (
    .clk    (CLK),
    .rst    (RST),
    .inc    (iREN && (state != IGNT)),
    .clr    (!iREN || ibeat),
    .limit  (LIMIT),
    .reached(starved)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      beat_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_n;
      beat_cnt <= beat_cnt_n;
      if ((state != IDLE) && (rs == ERROR)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign ram_err = err_q;

  always_comb begin
    state_n    = state;
    beat_cnt_n = beat_cnt;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    iwait      = 1'b1;
    dwait      = 1'b1;
    iload      = '0;
    dload      = '0;
    unique case (state)
      IDLE: begin
        beat_cnt_n = '0;
        if (dreq && !starved) begin
          state_n = DGNT;
        end else if (iREN) begin
          state_n = IGNT;
        end
      end
      IGNT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        iwait   = !access;
        iload   = ramload;
        if (access || !iREN) begin
          state_n = IDLE;
        end
      end
      DGNT: begin
        ramREN   = dREN;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dwait    = !access;
        dload    = ramload;
        // A dropped request after a beat ends the block early.
        if (!dreq) begin
          state_n    = IDLE;
          beat_cnt_n = '0;
        end else if (access) begin
          if (beat_cnt == LAST) begin
            state_n    = IDLE;
            beat_cnt_n = '0;
          end else begin
            beat_cnt_n = beat_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

`ifdef ARB_STATS_EN
  word_t icnt, dcnt;
  logic  dbeat;

  assign dbeat = (state == DGNT) && access && dreq;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      icnt <= '0;
      dcnt <= '0;
    end else begin
      if (ibeat) icnt <= icnt + 1'b1;
      if (dbeat) dcnt <= dcnt + 1'b1;
    end
  end

  assign igrant_count = icnt;
  assign dgrant_count = dcnt;
`else
  assign igrant_count = '0;
  assign dgrant_count = '0;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;
  localparam logic [1:0] R_FREE = 2'd0;
  localparam logic [1:0] R_BUSY = 2'd1;
  localparam logic [1:0] R_ACC  = 2'd2;
  localparam logic [1:0] R_ERR  = 2'd3;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic        dREN, dWEN;
  logic [31:0] daddr, dstore;
  logic [31:0] dload;
  logic        dwait;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        ram_err;
  logic [31:0] igrant_count, dgrant_count;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  mem_arbiter dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
    .ram_err(ram_err),
    .igrant_count(igrant_count), .dgrant_count(dgrant_count)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic mid();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b1; iREN = 0; iaddr = 0; dREN = 0; dWEN = 0;
    daddr = 0; dstore = 0; ramload = 32'hDEADBEEF; ramstate = R_FREE;
    mid();
    total++; if (iwait !== 1'b1) begin bad++; $display("FAIL rst_iwait got=%0h want=1", iwait); end
    total++; if (dwait !== 1'b1) begin bad++; $display("FAIL rst_dwait got=%0h want=1", dwait); end
    total++; if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin bad++; $display("FAIL rst_strobes got=%0h%0h want=00", ramREN, ramWEN); end
    total++; if (ramaddr !== 32'h0) begin bad++; $display("FAIL rst_ramaddr got=%0h want=0", ramaddr); end
    total++; if (iload !== 32'h0 || dload !== 32'h0) begin bad++; $display("FAIL rst_loads got=%0h/%0h want=0/0", iload, dload); end
    total++; if (ram_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%0h want=0", ram_err); end
    total++; if (igrant_count !== 0 || dgrant_count !== 0) begin bad++; $display("FAIL rst_counts got=%0d/%0d want=0/0", igrant_count, dgrant_count); end
    tick();
    RST = 1'b0;
  endtask

  task automatic test_icache_read();
    iREN = 1; iaddr = 32'h40; ramstate = R_FREE;
    mid();
    total++; if (ramREN !== 1'b0) begin bad++; $display("FAIL rd_c0_ren got=%0h want=0", ramREN); end
    tick();
    ramstate = R_BUSY;
    mid();
    total++; if (ramREN !== 1'b1) begin bad++; $display("FAIL rd_c1_ren got=%0h want=1", ramREN); end
    total++; if (ramaddr !== 32'h40) begin bad++; $display("FAIL rd_c1_addr got=%0h want=40", ramaddr); end
    total++; if (iwait !== 1'b1) begin bad++; $display("FAIL rd_c1_iwait got=%0h want=1", iwait); end
    tick();
    ramstate = R_ACC; ramload = 32'hCAFE0001;
    mid();
    total++; if (iwait !== 1'b0) begin bad++; $display("FAIL rd_c2_iwait got=%0h want=0", iwait); end
    total++; if (iload !== 32'hCAFE0001) begin bad++; $display("FAIL rd_c2_iload got=%0h want=cafe0001", iload); end
    total++; if (dload !== 32'h0 || dwait !== 1'b1) begin bad++; $display("FAIL rd_c2_dside got=%0h/%0h want=0/1", dload, dwait); end
    tick();
    iREN = 0; ramstate = R_FREE;
    mid();
    total++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin bad++; $display("FAIL rd_c3_idle got=%0h/%0h want=0/1", ramREN, iwait); end
    tick();
  endtask

  task automatic test_writeback();
    iREN = 1; iaddr = 32'h200;
    dWEN = 1; daddr = 32'h100; dstore = 32'h11111111; ramstate = R_FREE;
    mid();
    total++; if (ramWEN !== 1'b0) begin bad++; $display("FAIL wb_c0_wen got=%0h want=0", ramWEN); end
    tick();
    ramstate = R_ACC;
    mid();
    total++; if (ramWEN !== 1'b1 || ramaddr !== 32'h100) begin bad++; $display("FAIL wb_beat0 got=%0h/%0h want=1/100", ramWEN, ramaddr); end
    total++; if (ramstore !== 32'h11111111 || dwait !== 1'b0) begin bad++; $display("FAIL wb_beat0_data got=%0h/%0h want=11111111/0", ramstore, dwait); end
    total++; if (iwait !== 1'b1) begin bad++; $display("FAIL wb_beat0_iwait got=%0h want=1", iwait); end
    tick();
    daddr = 32'h104; dstore = 32'h22222222;
    mid();
    total++; if (ramaddr !== 32'h104 || ramstore !== 32'h22222222) begin bad++; $display("FAIL wb_beat1 got=%0h/%0h want=104/22222222", ramaddr, ramstore); end
    total++; if (iwait !== 1'b1 || dwait !== 1'b0) begin bad++; $display("FAIL wb_beat1_waits got=%0h/%0h want=1/0", iwait, dwait); end
    tick();
    dWEN = 0; ramstate = R_FREE;
    mid();
    total++; if (ramREN !== 1'b0 || ramaddr !== 32'h0) begin bad++; $display("FAIL wb_gap got=%0h/%0h want=0/0", ramREN, ramaddr); end
    tick();
    ramstate = R_ACC; dstore = 32'h33333333;
    mid();
    total++; if (ramaddr !== 32'h200 || iwait !== 1'b0) begin bad++; $display("FAIL wb_ifetch got=%0h/%0h want=200/0", ramaddr, iwait); end
    total++; if (ramstore !== 32'h0 || ramWEN !== 1'b0) begin bad++; $display("FAIL wb_ifetch_store got=%0h/%0h want=0/0", ramstore, ramWEN); end
    tick();
    iREN = 0; ramstate = R_FREE;
    tick();
  endtask

  task automatic test_starvation();
    iREN = 1; iaddr = 32'h400; dREN = 1; daddr = 32'h300; ramstate = R_BUSY;
    tick();
    for (int k = 0; k < 6; k++) begin
      mid();
      total++; if (ramaddr !== 32'h300 || dwait !== 1'b1) begin bad++; $display("FAIL sv_busy%0d got=%0h/%0h want=300/1", k, ramaddr, dwait); end
      tick();
    end
    ramstate = R_ACC;
    mid();
    total++; if (ramREN !== 1'b1 || dwait !== 1'b0) begin bad++; $display("FAIL sv_beat0 got=%0h/%0h want=1/0", ramREN, dwait); end
    tick();
    mid();
    total++; if (dwait !== 1'b0 || ramaddr !== 32'h300) begin bad++; $display("FAIL sv_beat1 got=%0h/%0h want=0/300", dwait, ramaddr); end
    tick();
    ramstate = R_FREE;
    mid();
    total++; if (ramREN !== 1'b0) begin bad++; $display("FAIL sv_gap got=%0h want=0", ramREN); end
    tick();
    ramstate = R_ACC;
    mid();
    total++; if (ramaddr !== 32'h400 || iwait !== 1'b0) begin bad++; $display("FAIL sv_igrant got=%0h/%0h want=400/0", ramaddr, iwait); end
    total++; if (dwait !== 1'b1) begin bad++; $display("FAIL sv_igrant_dwait got=%0h want=1", dwait); end
    tick();
    ramstate = R_FREE;
    tick();
    ramstate = R_BUSY;
    mid();
    total++; if (ramaddr !== 32'h300 || ramREN !== 1'b1) begin bad++; $display("FAIL sv_dagain got=%0h/%0h want=300/1", ramaddr, ramREN); end
    tick();
    iREN = 0; dREN = 0; ramstate = R_FREE;
    tick();
  endtask

  task automatic test_error();
    dWEN = 1; daddr = 32'h500; dstore = 32'h55; ramstate = R_FREE;
    tick();
    ramstate = R_ERR;
    mid();
    total++; if (dwait !== 1'b1 || ram_err !== 1'b0) begin bad++; $display("FAIL er_c1 got=%0h/%0h want=1/0", dwait, ram_err); end
    tick();
    mid();
    total++; if (ram_err !== 1'b1) begin bad++; $display("FAIL er_set got=%0h want=1", ram_err); end
    total++; if (dwait !== 1'b1 || ramWEN !== 1'b1) begin bad++; $display("FAIL er_hold got=%0h/%0h want=1/1", dwait, ramWEN); end
    tick();
    dWEN = 0; ramstate = R_FREE;
    tick();
    mid();
    total++; if (ram_err !== 1'b1 || ramWEN !== 1'b0) begin bad++; $display("FAIL er_sticky got=%0h/%0h want=1/0", ram_err, ramWEN); end
    tick();
  endtask

  task automatic test_reset_mid_beat();
    dWEN = 1; daddr = 32'h600; dstore = 32'h66; ramstate = R_FREE;
    tick();
    ramstate = R_ACC;
    mid();
    total++; if (ramWEN !== 1'b1 || dwait !== 1'b0) begin bad++; $display("FAIL rm_pre got=%0h/%0h want=1/0", ramWEN, dwait); end
    #2 RST = 1'b1;
    #1;
    total++; if (ramWEN !== 1'b0 || dwait !== 1'b1) begin bad++; $display("FAIL rm_async got=%0h/%0h want=0/1", ramWEN, dwait); end
    total++; if (ram_err !== 1'b0) begin bad++; $display("FAIL rm_err_clr got=%0h want=0", ram_err); end
    tick();
    RST = 1'b0; ramstate = R_FREE;
    mid();
    total++; if (ramWEN !== 1'b0) begin bad++; $display("FAIL rm_release got=%0h want=0", ramWEN); end
    tick();
    ramstate = R_ACC;
    mid();
    total++; if (ramWEN !== 1'b1 || ramaddr !== 32'h600) begin bad++; $display("FAIL rm_regrant got=%0h/%0h want=1/600", ramWEN, ramaddr); end
    tick();
    mid();
    total++; if (ramWEN !== 1'b1) begin bad++; $display("FAIL rm_second_beat got=%0h want=1", ramWEN); end
    tick();
    dWEN = 0; ramstate = R_ERR;
    mid();
    total++; if (ramWEN !== 1'b0) begin bad++; $display("FAIL rm_idle got=%0h want=0", ramWEN); end
    tick();
    mid();
    total++; if (ram_err !== 1'b0) begin bad++; $display("FAIL rm_idle_err got=%0h want=0", ram_err); end
    ramstate = R_FREE;
    tick();
  endtask

  task automatic test_stats();
    logic [31:0] exp_i;
    logic [31:0] exp_d;
`ifdef ARB_STATS_EN
    exp_i = 32'd3; exp_d = 32'd4;
`else
    exp_i = 32'd0; exp_d = 32'd0;
`endif
    RST = 1'b1;
    tick();
    RST = 1'b0; iREN = 1; iaddr = 32'h700; ramstate = R_ACC;
    for (int k = 0; k < 6; k++) tick();
    iREN = 0; dWEN = 1; daddr = 32'h800;
    for (int k = 0; k < 6; k++) tick();
    dWEN = 0; ramstate = R_FREE;
    mid();
    total++; if (igrant_count !== exp_i) begin bad++; $display("FAIL st_icount got=%0d want=%0d", igrant_count, exp_i); end
    total++; if (dgrant_count !== exp_d) begin bad++; $display("FAIL st_dcount got=%0d want=%0d", dgrant_count, exp_d); end
    tick();
  endtask

  initial begin
    test_reset();
    test_icache_read();
    test_writeback();
    test_starvation();
    test_error();
    test_reset_mid_beat();
    test_stats();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
